// File: rtl/func_pipe_if.sv
// Operand/result handshake bundle for func_pipe.
// The z_pop signal exists only when FUNC_PIPE_POPCOUNT_EN is defined.
interface func_pipe_if #(
  parameter int WIDTH = 8
);
  localparam int POP_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_mode;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             z_zero;
`ifdef FUNC_PIPE_POPCOUNT_EN
  logic [POP_W-1:0] z_pop;
`endif

  modport slave (
    input  in_valid, sel, a, b, acc_mode, acc_clr, out_ready,
    output in_ready, out_valid, z, z_zero
`ifdef FUNC_PIPE_POPCOUNT_EN
    , output z_pop
`endif
  );

  modport master (
    output in_valid, sel, a, b, acc_mode, acc_clr, out_ready,
    input  in_ready, out_valid, z, z_zero
`ifdef FUNC_PIPE_POPCOUNT_EN
    , input z_pop
`endif
  );
endinterface

// File: rtl/func_pipe.sv
// Two-stage elastic pipeline applying a per-beat 4-bit truth table bitwise, with accumulate feedback.
// Optional popcount output enabled by defining FUNC_PIPE_POPCOUNT_EN.
module func_pipe #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  func_pipe_if.slave bus
);
  localparam int POP_W = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] apply_tt(input logic [3:0] tt,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = tt[{x[i], y[i]}];
    return r;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) cnt = cnt + POP_W'(v[i]);
    return cnt;
  endfunction

  logic             vld_p1_q, vld_p1_d;
  logic [3:0]       sel_p1_q;
  logic [WIDTH-1:0] a_p1_q, b_p1_q;
  logic             mode_p1_q;
  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] z_p2_q, z_d;
  logic             zz_p2_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             s2_load, in_ready, accept;

  always_comb begin
    s2_load  = vld_p1_q && (!vld_p2_q || bus.out_ready);
    in_ready = rst_n && (!vld_p1_q || s2_load);
    accept   = bus.in_valid && in_ready;
    // Accumulator is read in the load cycle so chained acc_mode beats see the previous result.
    z_d      = apply_tt(sel_p1_q, a_p1_q, mode_p1_q ? acc_q : b_p1_q);
    vld_p1_d = accept || (vld_p1_q && !s2_load);
    vld_p2_d = s2_load || (vld_p2_q && !bus.out_ready);
    acc_d    = s2_load ? z_d : (bus.acc_clr ? '0 : acc_q);
  end

  // Stage 1: operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1_q <= 1'b0;
    else        vld_p1_q <= vld_p1_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sel_p1_q  <= bus.sel;
      a_p1_q    <= bus.a;
      b_p1_q    <= bus.b;
      mode_p1_q <= bus.acc_mode;
    end
  end

  // Stage 2: result, flags and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q <= 1'b0;
      z_p2_q   <= '0;
      zz_p2_q  <= 1'b1;
      acc_q    <= '0;
    end else begin
      vld_p2_q <= vld_p2_d;
      acc_q    <= acc_d;
      if (s2_load) begin
        z_p2_q  <= z_d;
        zz_p2_q <= (z_d == '0);
      end
    end
  end

`ifdef FUNC_PIPE_POPCOUNT_EN
  logic [POP_W-1:0] pop_p2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pop_p2_q <= '0;
    else if (s2_load) pop_p2_q <= popcount(z_d);
  end

  assign bus.z_pop = pop_p2_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p2_q;
  assign bus.z         = z_p2_q;
  assign bus.z_zero    = zz_p2_q;
endmodule

// File: tb/tb_func_pipe.sv
// Self-checking bench for func_pipe: truth-table vectors, random streams vs. a set-algebra model,
// and hand-written accumulate, backpressure and reset sequences.
module tb_func_pipe;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  func_pipe_if #(.WIDTH(W)) bus();
  func_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Result = union of the operand-pair regions whose truth-table entry is set.
  function automatic logic [W-1:0] ref_fn(input logic [3:0] s, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [W-1:0] r;
    r = '0;
    if (s[0]) r = r | (~x & ~y);
    if (s[1]) r = r | (~x &  y);
    if (s[2]) r = r | ( x & ~y);
    if (s[3]) r = r | ( x &  y);
    return r;
  endfunction

  typedef struct {
    logic [3:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] z;
  } vec_t;
  vec_t tbl[16];
  logic [W-1:0] zexp [16];

  logic [W-1:0] expq[$];
  logic [W-1:0] model_acc = '0;
  bit           sb_en = 1'b0;
  int           pushed = 0;
  int           popped = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: in-order results, accumulator = previous result in stream order.
  initial begin
    bit           stall_prev;
    logic [W-1:0] z_prev;
    logic [W-1:0] e;
    stall_prev = 1'b0;
    z_prev = '0;
    forever begin
      @(negedge clk);
      if (sb_en && rst_n) begin
        if (stall_prev) begin
          chk("hold_valid", 32'(bus.out_valid), 32'd1);
          chk("hold_z", 32'(bus.z), 32'(z_prev));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_beat actual=%0h required=none", bus.z);
          end else begin
            e = expq.pop_front();
            popped++;
            chk("stream_z", 32'(bus.z), 32'(e));
            chk("stream_zero", 32'(bus.z_zero), 32'(e == '0));
`ifdef FUNC_PIPE_POPCOUNT_EN
            chk("stream_pop", 32'(bus.z_pop), 32'($countones(e)));
`endif
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          e = ref_fn(bus.sel, bus.a, bus.acc_mode ? model_acc : bus.b);
          model_acc = e;
          expq.push_back(e);
          pushed++;
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        z_prev = bus.z;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    expq.delete();
    model_acc = '0;
    pushed = 0;
    popped = 0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic run_stream(input int n, input int bp_start, input int bp_len, input bit bubbles,
                            output bit rdy_all, output bit rdy_bp, output int cycles);
    int sent;
    bit pend;
    bit fire;
    bit in_bp;
    sent = 0;
    pend = 1'b0;
    cycles = 0;
    rdy_all = 1'b1;
    rdy_bp = 1'b1;
    while (sent < n && cycles < 2000) begin
      if (!pend) begin
        if (!bubbles || $urandom_range(3) != 0) begin
          bus.in_valid = 1'b1;
          bus.sel      = 4'($urandom_range(15));
          bus.a        = W'($urandom);
          bus.b        = W'($urandom);
          bus.acc_mode = 1'($urandom_range(1));
          pend = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      in_bp = (cycles >= bp_start) && (cycles < bp_start + bp_len);
      bus.out_ready = !in_bp;
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      if (!bus.in_ready) rdy_all = 1'b0;
      if (in_bp && !bus.in_ready) rdy_bp = 1'b0;
      @(posedge clk);
      #1;
      if (fire) begin
        pend = 1'b0;
        sent++;
      end
      cycles++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_sent", 32'(sent), 32'(n));
    repeat (4) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit rdy_all, rdy_bp;
    int cyc;
    zexp = '{8'h00, 8'hC0, 8'h30, 8'hF0, 8'h0C, 8'hCC, 8'h3C, 8'hFC,
             8'h03, 8'hC3, 8'h33, 8'hF3, 8'h0F, 8'hCF, 8'h3F, 8'hFF};
    for (int i = 0; i < 16; i++) begin
      tbl[i].sel = 4'(i);
      tbl[i].a   = 8'h0F;
      tbl[i].b   = 8'h33;
      tbl[i].z   = zexp[i];
    end

    bus.in_valid = 1'b0; bus.sel = '0; bus.a = '0; bus.b = '0;
    bus.acc_mode = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_z", 32'(bus.z), 32'd0);
    chk("rst_z_zero", 32'(bus.z_zero), 32'd1);
`ifdef FUNC_PIPE_POPCOUNT_EN
    chk("rst_z_pop", 32'(bus.z_pop), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // Truth-table vectors with latency check
    for (int i = 0; i < 16; i++) begin
      bus.sel = tbl[i].sel; bus.a = tbl[i].a; bus.b = tbl[i].b;
      bus.acc_mode = 1'b0; bus.in_valid = 1'b1;
      chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      chk("t1_lat_early", 32'(bus.out_valid), 32'd0);
      step();
      chk("t1_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_z", 32'(bus.z), 32'(tbl[i].z));
      chk("t1_z_zero", 32'(bus.z_zero), 32'(tbl[i].z == '0));
      chk("t1_model", 32'(ref_fn(tbl[i].sel, tbl[i].a, tbl[i].b)), 32'(bus.z));
`ifdef FUNC_PIPE_POPCOUNT_EN
      chk("t1_z_pop", 32'(bus.z_pop), 32'($countones(tbl[i].z)));
`endif
    end
    step();

    // Back-to-back streaming
    do_reset();
    sb_en = 1'b1;
    run_stream(16, 1000, 0, 1'b0, rdy_all, rdy_bp, cyc);
    chk("t2_in_ready_high", 32'(rdy_all), 32'd1);
    chk("t2_cycles", 32'(cyc), 32'd16);
    chk("t2_popped", 32'(popped), 32'd16);
    chk("t2_q_empty", 32'(expq.size()), 32'd0);

    // Backpressure mid-stream
    do_reset();
    run_stream(20, 6, 5, 1'b0, rdy_all, rdy_bp, cyc);
    chk("t3_in_ready_drop", 32'(rdy_bp), 32'd0);
    chk("t3_popped", 32'(popped), 32'd20);
    chk("t3_q_empty", 32'(expq.size()), 32'd0);

    // Random bubbles and backpressure
    do_reset();
    run_stream(40, 10, 4, 1'b1, rdy_all, rdy_bp, cyc);
    chk("t3r_popped", 32'(popped), 32'(pushed));
    chk("t3r_q_empty", 32'(expq.size()), 32'd0);
    sb_en = 1'b0;

    // Accumulate chain
    bus.acc_clr = 1'b1; bus.in_valid = 1'b0;
    step();
    bus.acc_clr = 1'b0;
    bus.sel = 4'b0110; bus.acc_mode = 1'b1; bus.b = 8'hAA; bus.in_valid = 1'b1;
    bus.a = 8'h01;
    step();
    bus.a = 8'h02;
    step();
    chk("t4_z1", 32'(bus.z), 32'h01);
    bus.a = 8'h04;
    step();
    chk("t4_z2", 32'(bus.z), 32'h03);
    bus.in_valid = 1'b0;
    step();
    chk("t4_z3", 32'(bus.z), 32'h07);
    // Clear coinciding with a load: load wins
    bus.a = 8'h10; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0; bus.acc_clr = 1'b1;
    step();
    bus.acc_clr = 1'b0;
    chk("t4_clr_load_z", 32'(bus.z), 32'h17);
    bus.a = 8'h00; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("t4_acc_kept", 32'(bus.z), 32'h17);
    // Lone clear empties the accumulator
    bus.acc_clr = 1'b1;
    step();
    bus.acc_clr = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("t4_acc_cleared", 32'(bus.z), 32'h00);
    chk("t4_zero_flag", 32'(bus.z_zero), 32'd1);

    // Reset with both stages full
    bus.acc_mode = 1'b0; bus.out_ready = 1'b0;
    bus.sel = 4'b1111; bus.in_valid = 1'b1;
    step();
    step();
    bus.in_valid = 1'b0;
    chk("t5_full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t5_full_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_z", 32'(bus.z), 32'd0);
    chk("t5_rst_zero", 32'(bus.z_zero), 32'd1);
    chk("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("t5_rst_in_ready2", 32'(bus.in_ready), 32'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("t5_rel_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_no_stale", 32'(bus.out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
